debouncer: RTL and testbench

Cleans a raw mechanical-switch input into a glitch-free level for the dual-edge detector stage, which consumes `db_level` as its `level` input. Synchronizes the asynchronous input with a 2-flop synchronizer, then commits a level change only after the synchronized input has held the new value for a full countdown of 2^N − 1 cycles. Also emits a one-cycle `db_tick` on each committed rising edge.

---
 rtl/debouncer.sv | 97 +++++++++
 tb/tb_debouncer.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/debouncer.sv
// Switch debouncer: 2-flop synchronizer followed by a countdown FSM that commits
// a level change only after the input has been stable for a full window.
module debouncer #(
  parameter int unsigned N = 20
) (
  input  logic clk,
  input  logic reset,
  input  logic sw,
  output logic db_level,
  output logic db_tick
);

  localparam logic [N-1:0] Q_MAX = '1;

  typedef enum logic [1:0] {
    ZERO  = 2'd0,
    WAIT1 = 2'd1,
    ONE   = 2'd2,
    WAIT0 = 2'd3
  } state_t;

  state_t       state, state_next;
  logic [N-1:0] q, q_next;
  logic         sync1, sync2;
  logic         s;

  // Synchronizer for the asynchronous switch input
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= sw;
      sync2 <= sync1;
    end
  end

  assign s = sync2;

  // State, countdown and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ZERO;
      q        <= '0;
      db_level <= 1'b0;
      db_tick  <= 1'b0;
    end else begin
      state    <= state_next;
      q        <= q_next;
      db_level <= (state_next == ONE) || (state_next == WAIT0);
      db_tick  <= (state == WAIT1) && (state_next == ONE);
    end
  end

  // Next-state logic; a revert always takes priority over an expiring count
  always_comb begin
    state_next = state;
    q_next     = q;
    unique case (state)
      ZERO: begin
        if (s) begin
          state_next = WAIT1;
          q_next     = Q_MAX;
        end
      end
      WAIT1: begin
        if (!s) begin
          state_next = ZERO;
        end else if (q == '0) begin
          state_next = ONE;
        end else begin
          q_next = q - N'(1);
        end
      end
      ONE: begin
        if (!s) begin
          state_next = WAIT0;
          q_next     = Q_MAX;
        end
      end
      WAIT0: begin
        if (s) begin
          state_next = ONE;
        end else if (q == '0) begin
          state_next = ZERO;
        end else begin
          q_next = q - N'(1);
        end
      end
      default: begin
        state_next = ZERO;
        q_next     = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_debouncer.sv
// Self-checking bench for debouncer (N=3) against a run-length reference model.
module tb_debouncer;

  localparam int unsigned N   = 3;
  // Consecutive differing synchronized samples needed to commit: 2^N + 1
  localparam int unsigned WIN = (1 << N) + 1;

  logic clk;
  logic reset;
  logic sw;
  logic db_level;
  logic db_tick;

  int total;
  int bad;

  debouncer #(.N(N)) dut (
    .clk      (clk),
    .reset    (reset),
    .sw       (sw),
    .db_level (db_level),
    .db_tick  (db_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: delay sw by two samples, then flip the level once the
  // delayed input has disagreed with it for WIN consecutive samples.
  logic [1:0] mpipe;
  int         run;
  logic       exp_level;
  logic       exp_tick;

  always @(posedge clk or negedge reset) begin
    logic ms;
    if (!reset) begin
      mpipe     = 2'b00;
      run       = 0;
      exp_level = 1'b0;
      exp_tick  = 1'b0;
    end else begin
      ms       = mpipe[1];
      exp_tick = 1'b0;
      if (ms !== exp_level) begin
        run = run + 1;
        if (run == int'(WIN)) begin
          exp_level = ms;
          exp_tick  = ms;
          run       = 0;
        end
      end else begin
        run = 0;
      end
      mpipe = {mpipe[0], sw};
    end
  end

  task automatic settle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    sw    = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      total++;
      if (db_level !== 1'b0 || db_tick !== 1'b0) begin
        bad++;
        $display("FAIL reset_hold cyc=%0d got level=%b tick=%b want 0/0", i, db_level, db_tick);
      end
      sw = 1'($urandom_range(0, 1));
    end
    sw    = 1'b0;
    reset = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      total++;
      if (db_level !== 1'b0 || db_tick !== 1'b0) begin
        bad++;
        $display("FAIL reset_release cyc=%0d got level=%b tick=%b want 0/0", i, db_level, db_tick);
      end
    end
  endtask

  task automatic test_clean_rise();
    sw = 1'b1;
    for (int e = 0; e < 20; e++) begin
      @(negedge clk);
      total++;
      if (db_level !== (e >= 10) || db_tick !== (e == 10)) begin
        bad++;
        $display("FAIL clean_rise edge=%0d got level=%b tick=%b want %b/%b",
                 e, db_level, db_tick, e >= 10, e == 10);
      end
      total++;
      if (db_level !== exp_level || db_tick !== exp_tick) begin
        bad++;
        $display("FAIL clean_rise_model edge=%0d got %b/%b want %b/%b",
                 e, db_level, db_tick, exp_level, exp_tick);
      end
    end
  endtask

  task automatic test_bounce();
    int lens[3] = '{1, 3, 6};
    sw = 1'b0;
    settle(15);
    for (int p = 0; p < 3; p++) begin
      sw = 1'b1;
      for (int i = 0; i < lens[p]; i++) begin
        @(negedge clk);
        total++;
        if (db_level !== 1'b0 || db_tick !== 1'b0) begin
          bad++;
          $display("FAIL bounce_hi pulse=%0d got %b/%b want 0/0", lens[p], db_level, db_tick);
        end
      end
      sw = 1'b0;
      for (int i = 0; i < 4 + int'($urandom_range(0, 3)); i++) begin
        @(negedge clk);
        total++;
        if (db_level !== 1'b0 || db_tick !== 1'b0) begin
          bad++;
          $display("FAIL bounce_gap pulse=%0d got %b/%b want 0/0", lens[p], db_level, db_tick);
        end
      end
    end
    settle(12);
    sw = 1'b1;
    for (int e = 0; e < 14; e++) begin
      @(negedge clk);
      total++;
      if (db_level !== (e >= 10) || db_tick !== (e == 10)) begin
        bad++;
        $display("FAIL bounce_commit edge=%0d got %b/%b want %b/%b",
                 e, db_level, db_tick, e >= 10, e == 10);
      end
    end
  endtask

  task automatic test_fall_glitch();
    sw = 1'b0;
    for (int i = 0; i < 4; i++) @(negedge clk);
    sw = 1'b1;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      total++;
      if (db_level !== 1'b1 || db_tick !== 1'b0) begin
        bad++;
        $display("FAIL glitch_low cyc=%0d got %b/%b want 1/0", i, db_level, db_tick);
      end
    end
    sw = 1'b0;
    for (int e = 0; e < 14; e++) begin
      @(negedge clk);
      total++;
      if (db_level !== (e < 10) || db_tick !== 1'b0) begin
        bad++;
        $display("FAIL clean_fall edge=%0d got %b/%b want %b/0", e, db_level, db_tick, e < 10);
      end
    end
  endtask

  task automatic test_boundary();
    // An 8-cycle pulse makes s revert exactly when q reaches 0
    sw = 1'b1;
    for (int e = 0; e < 8; e++) @(negedge clk);
    sw = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      total++;
      if (db_level !== 1'b0 || db_tick !== 1'b0) begin
        bad++;
        $display("FAIL boundary_wait1 cyc=%0d got %b/%b want 0/0", i, db_level, db_tick);
      end
    end
    // One cycle longer commits
    sw = 1'b1;
    for (int e = 0; e < 9; e++) @(negedge clk);
    sw = 1'b0;
    for (int e = 9; e < 13; e++) begin
      @(negedge clk);
      total++;
      if (db_level !== (e >= 10) || db_tick !== (e == 10)) begin
        bad++;
        $display("FAIL boundary_commit edge=%0d got %b/%b want %b/%b",
                 e, db_level, db_tick, e >= 10, e == 10);
      end
    end
    sw = 1'b1;
    settle(14);
    sw = 1'b0;
    for (int e = 0; e < 8; e++) @(negedge clk);
    sw = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      total++;
      if (db_level !== 1'b1 || db_tick !== 1'b0) begin
        bad++;
        $display("FAIL boundary_wait0 cyc=%0d got %b/%b want 1/0", i, db_level, db_tick);
      end
    end
  endtask

  task automatic test_async_reset();
    sw = 1'b0;
    settle(14);
    sw = 1'b1;
    for (int e = 0; e < 6; e++) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    total++;
    if (db_level !== 1'b0 || db_tick !== 1'b0) begin
      bad++;
      $display("FAIL async_reset_immediate got %b/%b want 0/0", db_level, db_tick);
    end
    settle(3);
    reset = 1'b1;
    for (int e = 0; e < 14; e++) begin
      @(negedge clk);
      total++;
      if (db_level !== (e >= 10) || db_tick !== (e == 10)) begin
        bad++;
        $display("FAIL async_reset_recommit edge=%0d got %b/%b want %b/%b",
                 e, db_level, db_tick, e >= 10, e == 10);
      end
    end
  endtask

  task automatic test_random();
    int ticks;
    int exp_ticks;
    ticks     = 0;
    exp_ticks = 0;
    for (int b = 0; b < 60; b++) begin
      sw = 1'($urandom_range(0, 1));
      for (int i = 0; i < int'($urandom_range(1, 14)); i++) begin
        @(negedge clk);
        ticks     += int'(db_tick);
        exp_ticks += int'(exp_tick);
        total++;
        if (db_level !== exp_level || db_tick !== exp_tick) begin
          bad++;
          $display("FAIL random burst=%0d got %b/%b want %b/%b",
                   b, db_level, db_tick, exp_level, exp_tick);
        end
      end
    end
    total++;
    if (ticks !== exp_ticks) begin
      bad++;
      $display("FAIL random_tick_count got %0d want %0d", ticks, exp_ticks);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b0;
    sw    = 1'b0;
    test_reset();
    test_clean_rise();
    test_bounce();
    test_fall_glitch();
    test_boundary();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
